inv_sched: RTL and testbench

INV_SCHED -- requirements
Module: inv_sched

---
 rtl/inv_pkg.sv | 56 +++++
 rtl/inv_chain_rom.sv | 14 +
 rtl/inv_sched.sv | 145 ++++++++++++++
 tb/tb_inv_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_pkg.sv
// Shared constants, FSM encoding and the addition-chain tables for the
// inversion scheduler.
package inv_pkg;

  localparam int R         = 10163;
  localparam int CHAIN_LEN = 13;
  localparam int DEG_W     = 14;
  localparam int STEP_W    = 4;
  localparam int EXP_W     = 14;

  // Bit i is set when chain entry i+1 = 2*entry i + 1.
  localparam logic [15:0] CHAIN_ODD = 16'h11BC;

  typedef enum logic [3:0] {
    IDLE,
    EXP_K,
    W_EXP_K,
    MUL_B,
    W_MUL_B,
    EXP_1,
    W_EXP_1,
    MUL_A,
    W_MUL_A,
    NEXT,
    FIN_EXP,
    W_FIN,
    DONE
  } state_t;

  // Exponent reached before chain step idx.
  function automatic logic [EXP_W-1:0] chain_exp(input logic [STEP_W-1:0] idx);
    case (idx)
      4'd0:    return 14'd1;
      4'd1:    return 14'd2;
      4'd2:    return 14'd4;
      4'd3:    return 14'd9;
      4'd4:    return 14'd19;
      4'd5:    return 14'd39;
      4'd6:    return 14'd79;
      4'd7:    return 14'd158;
      4'd8:    return 14'd317;
      4'd9:    return 14'd635;
      4'd10:   return 14'd1270;
      4'd11:   return 14'd2540;
      4'd12:   return 14'd5080;
      4'd13:   return 14'd10161;
      default: return 14'd0;
    endcase
  endfunction

  // Whether step idx needs the extra square-and-multiply-by-a.
  function automatic logic chain_odd(input logic [STEP_W-1:0] idx);
    return CHAIN_ODD[idx];
  endfunction

endpackage

// File: rtl/inv_chain_rom.sv
// Combinational addition-chain ROM: step index in, {exponent, odd flag} out.
module inv_chain_rom #(
  parameter int DEG_W = inv_pkg::DEG_W
) (
  input  logic [3:0]       step,
  output logic [DEG_W-1:0] exp_deg,
  output logic             odd
);
  import inv_pkg::*;

  assign exp_deg = DEG_W'(chain_exp(step));
  assign odd     = chain_odd(step);

endmodule

// File: rtl/inv_sched.sv
// Inversion scheduler: walks the addition chain, sequencing the 2^-k
// permutation unit and the polynomial multiplier through handshakes.
module inv_sched #(
  parameter int R         = inv_pkg::R,
  parameter int CHAIN_LEN = inv_pkg::CHAIN_LEN,
  parameter int DEG_W     = inv_pkg::DEG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             exp_start,
  output logic [DEG_W-1:0] exp_deg,
  input  logic             exp_done,
  output logic             mul_start,
  output logic             mul_sel,
  input  logic             mul_done,
  output logic [3:0]       step
);
  import inv_pkg::*;

  localparam logic [3:0] LAST_STEP = 4'(CHAIN_LEN - 1);

  state_t           state;
  state_t           state_nx;
  logic             step_inc;
  logic             start_acc;
  logic             exp_wait;
  logic             mul_wait;
  logic             proto_err;
  logic [DEG_W-1:0] rom_deg;
  logic             rom_odd;

  inv_chain_rom #(.DEG_W(DEG_W)) u_rom (
    .step    (step),
    .exp_deg (rom_deg),
    .odd     (rom_odd)
  );

  assign start_acc = (state == IDLE) && start;
  assign exp_wait  = (state == W_EXP_K) || (state == W_EXP_1) || (state == W_FIN);
  assign mul_wait  = (state == W_MUL_B) || (state == W_MUL_A);

  // A completion pulse nobody is waiting for, or both at once, is a protocol error.
  assign proto_err = (exp_done && !exp_wait) || (mul_done && !mul_wait) ||
                     (exp_done && mul_done);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; a completion pulse is honoured only in its wait state.
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    step_inc = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = EXP_K;
      EXP_K:   state_nx = W_EXP_K;
      W_EXP_K: if (exp_done) state_nx = MUL_B;
      MUL_B:   state_nx = W_MUL_B;
      W_MUL_B: if (mul_done) state_nx = NEXT;
      NEXT: begin
        if (rom_odd) begin
          state_nx = EXP_1;
        end else if (step == LAST_STEP) begin
          state_nx = FIN_EXP;
        end else begin
          state_nx = EXP_K;
          step_inc = 1'b1;
        end
      end
      EXP_1:   state_nx = W_EXP_1;
      W_EXP_1: if (exp_done) state_nx = MUL_A;
      MUL_A:   state_nx = W_MUL_A;
      W_MUL_A: begin
        if (mul_done) begin
          if (step == LAST_STEP) begin
            state_nx = FIN_EXP;
          end else begin
            state_nx = EXP_K;
            step_inc = 1'b1;
          end
        end
      end
      FIN_EXP: state_nx = W_FIN;
      W_FIN:   if (exp_done) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered strobes, operand selects, step counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      exp_start <= 1'b0;
      mul_start <= 1'b0;
      mul_sel   <= 1'b0;
      exp_deg   <= '0;
    end else begin
      exp_start <= (state == EXP_K) || (state == EXP_1) || (state == FIN_EXP);
      mul_start <= (state == MUL_B) || (state == MUL_A);
      done      <= (state == DONE);

      // Operands are captured with the strobe and held until the next launch.
      if (state == EXP_K)
        exp_deg <= rom_deg;
      else if ((state == EXP_1) || (state == FIN_EXP))
        exp_deg <= DEG_W'(1);

      if (state == MUL_B)
        mul_sel <= 1'b0;
      else if (state == MUL_A)
        mul_sel <= 1'b1;

      if (start_acc)
        step <= '0;
      else if (step_inc && (step != LAST_STEP))
        step <= step + 4'd1;

      // busy stays up through the done pulse and drops the cycle after.
      if (start_acc)
        busy <= 1'b1;
      else if (done)
        busy <= 1'b0;

      if (proto_err)
        err <= 1'b1;
      else if (start_acc)
        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inv_sched.sv
// Directed-sequence bench for inv_sched with handshake responders and a
// chain-level reference model of the expected strobe stream.
module tb_inv_sched;

  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, err;
  logic          exp_start, mul_start, mul_sel;
  logic [DW-1:0] exp_deg;
  logic [3:0]    step;
  logic          exp_done, mul_done;
  logic          resp_exp, resp_mul, inj_exp, inj_mul;

  assign exp_done = resp_exp | inj_exp;
  assign mul_done = resp_mul | inj_mul;

  always #5 clk = ~clk;

  inv_sched #(.R(10163), .CHAIN_LEN(13), .DEG_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .exp_start (exp_start),
    .exp_deg   (exp_deg),
    .exp_done  (exp_done),
    .mul_start (mul_start),
    .mul_sel   (mul_sel),
    .mul_done  (mul_done),
    .step      (step)
  );

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  bit rand_lat = 1'b0;
  int exp_cnt = 0;
  int mul_cnt = 0;

  int obs_exp_deg[$], obs_exp_step[$], obs_mul_sel[$], obs_mul_step[$];
  int mdl_exp_deg[$], mdl_exp_step[$], mdl_mul_sel[$], mdl_mul_step[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int pick_lat();
    return rand_lat ? int'($urandom_range(1, 4)) : 3;
  endfunction

  // Reference: the strobe stream implied by the addition chain itself.
  task automatic build_model();
    int chain [0:13] = '{1, 2, 4, 9, 19, 39, 79, 158, 317, 635, 1270, 2540, 5080, 10161};
    for (int i = 0; i < 13; i++) begin
      mdl_exp_deg.push_back(chain[i]);  mdl_exp_step.push_back(i);
      mdl_mul_sel.push_back(0);         mdl_mul_step.push_back(i);
      if (chain[i+1] - 2 * chain[i] == 1) begin
        mdl_exp_deg.push_back(1);       mdl_exp_step.push_back(i);
        mdl_mul_sel.push_back(1);       mdl_mul_step.push_back(i);
      end
    end
    mdl_exp_deg.push_back(1);
    mdl_exp_step.push_back(12);
  endtask

  // Responders and strobe logger, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0; mul_cnt = 0; resp_exp = 1'b0; resp_mul = 1'b0;
    end else begin
      resp_exp = 1'b0;
      resp_mul = 1'b0;
      if (exp_cnt > 0) begin exp_cnt--; if (exp_cnt == 0) resp_exp = 1'b1; end
      if (mul_cnt > 0) begin mul_cnt--; if (mul_cnt == 0) resp_mul = 1'b1; end
      if (exp_start) begin
        exp_cnt = pick_lat();
        obs_exp_deg.push_back(int'(exp_deg));
        obs_exp_step.push_back(int'(step));
      end
      if (mul_start) begin
        mul_cnt = pick_lat();
        obs_mul_sel.push_back(int'(mul_sel));
        obs_mul_step.push_back(int'(step));
      end
      if (exp_start || mul_start)
        chk("strobe_overlap", {31'b0, exp_start & mul_start}, 0);
      if (done) done_cnt++;
    end
  end

  task automatic clear_logs();
    obs_exp_deg.delete(); obs_exp_step.delete();
    obs_mul_sel.delete(); obs_mul_step.delete();
    done_cnt = 0;
  endtask

  task automatic start_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_busy", {31'b0, busy}, 1);
    chk("start_err_clear", {31'b0, err}, 0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
    chk("done_seen", {31'b0, done_cnt > 0}, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_strobe(input bit is_mul, input int sel, input int stp, input int budget);
    bit found = 1'b0;
    int n = 0;
    while (!found && n < budget) begin
      @(negedge clk); n++;
      if (is_mul) found = mul_start && (int'(mul_sel) == sel) && (int'(step) == stp);
      else        found = exp_start && (int'(step) == stp);
    end
    chk(is_mul ? "wait_mul_strobe" : "wait_exp_strobe", {31'b0, found}, 1);
  endtask

  task automatic compare_run(input string tag);
    int n;
    chk({tag, "_exp_count"}, obs_exp_deg.size(), mdl_exp_deg.size());
    chk({tag, "_mul_count"}, obs_mul_sel.size(), mdl_mul_sel.size());
    chk({tag, "_done_count"}, done_cnt, 1);
    n = (obs_exp_deg.size() < mdl_exp_deg.size()) ? obs_exp_deg.size() : mdl_exp_deg.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_exp_deg[%0d]", tag, i), obs_exp_deg[i], mdl_exp_deg[i]);
      chk($sformatf("%s_exp_step[%0d]", tag, i), obs_exp_step[i], mdl_exp_step[i]);
    end
    n = (obs_mul_sel.size() < mdl_mul_sel.size()) ? obs_mul_sel.size() : mdl_mul_sel.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_mul_sel[%0d]", tag, i), obs_mul_sel[i], mdl_mul_sel[i]);
      chk($sformatf("%s_mul_step[%0d]", tag, i), obs_mul_step[i], mdl_mul_step[i]);
    end
  endtask

  task automatic check_all_low(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
    chk({tag, "_err"}, {31'b0, err}, 0);
    chk({tag, "_exp_start"}, {31'b0, exp_start}, 0);
    chk({tag, "_mul_start"}, {31'b0, mul_start}, 0);
    chk({tag, "_mul_sel"}, {31'b0, mul_sel}, 0);
    chk({tag, "_exp_deg"}, {18'b0, exp_deg}, 0);
    chk({tag, "_step"}, {28'b0, step}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;
    rst = 1'b1; start = 1'b0; inj_exp = 1'b0; inj_mul = 1'b0;
    resp_exp = 1'b0; resp_mul = 1'b0;
    build_model();

    // Reset state.
    repeat (2) @(negedge clk);
    check_all_low("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full run with fixed 3-cycle acknowledgements.
    clear_logs(); rand_lat = 1'b0;
    start_run();
    wait_done(2000);
    compare_run("run3");
    chk("run3_err", {31'b0, err}, 0);
    chk("run3_busy_after", {31'b0, busy}, 0);

    // Asynchronous reset while waiting on the multiplier at step 6.
    clear_logs();
    start_run();
    wait_strobe(1'b1, 0, 6, 1000);
    #2 rst = 1'b1;
    #1 check_all_low("abort");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    clear_logs();
    start_run();
    wait_done(2000);
    chk("restart_first_seen", {31'b0, obs_exp_deg.size() > 0}, 1);
    if (obs_exp_deg.size() > 0) begin
      chk("restart_first_deg", obs_exp_deg[0], 1);
      chk("restart_first_step", obs_exp_step[0], 0);
    end
    compare_run("restart");

    // Stray mul_done while waiting on the permutation unit.
    clear_logs();
    start_run();
    wait_strobe(1'b0, 0, 0, 100);
    @(negedge clk); inj_mul = 1'b1;
    @(negedge clk); inj_mul = 1'b0;
    chk("stray_err", {31'b0, err}, 1);
    chk("stray_step", {28'b0, step}, 0);
    chk("stray_no_mul", {31'b0, mul_start}, 0);
    chk("stray_mul_log", obs_mul_sel.size(), 0);
    wait_done(2000);
    compare_run("stray");
    chk("stray_err_sticky", {31'b0, err}, 1);

    // New start clears err; a start while busy is ignored (random latencies).
    clear_logs(); rand_lat = 1'b1;
    start_run();
    repeat (25) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_start_busy", {31'b0, busy}, 1);
    wait_done(3000);
    compare_run("rand");
    chk("rand_err", {31'b0, err}, 0);

    // Both completions together while in the extra-square wait at step 2.
    clear_logs(); rand_lat = 1'b0;
    start_run();
    wait_strobe(1'b1, 0, 2, 1000);
    wait_strobe(1'b0, 0, 2, 100);
    repeat (3) @(negedge clk);
    inj_mul = 1'b1;
    @(negedge clk); inj_mul = 1'b0;
    chk("both_err", {31'b0, err}, 1);
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      seen = exp_start || mul_start;
    end
    chk("both_next_seen", {31'b0, seen}, 1);
    chk("both_next_mul", {31'b0, mul_start}, 1);
    chk("both_next_sel", {31'b0, mul_sel}, 1);
    chk("both_next_step", {28'b0, step}, 2);
    wait_done(2000);
    compare_run("both");
    chk("both_err_sticky", {31'b0, err}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
